// File: rtl/uart_rx_core.sv
// UART receive core: oversampled start/data/parity/stop framing with a one-deep
// holding register, overrun detection and break detection.
module uart_rx_core #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BAUD_CLK,
  input  logic       RXD,
  input  logic [1:0] WLS,
  input  logic       PEN,
  input  logic       EPS,
  input  logic       RD_ACK,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       PE,
  output logic       FE,
  output logic       BI,
  output logic       OE
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t          state_q, state_d;
  logic            rxd_meta, rxd_s;
  logic            baud_q;
  logic            tick;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      shift_q;
  logic            par_q;
  logic            stop_q;
  logic            load_q;
  logic [1:0]      wls_q;
  logic            pen_q;
  logic            eps_q;
  logic            half_hit, bit_hit, last_bit;
  logic            start_ok, stop_hit;
  logic            par_x, new_pe, new_fe, new_bi;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
      baud_q   <= 1'b0;
    end else begin
      rxd_meta <= RXD;
      rxd_s    <= rxd_meta;
      baud_q   <= BAUD_CLK;
    end
  end

  assign tick     = BAUD_CLK & ~baud_q;
  assign half_hit = tick && (cnt_q == CNT_HALF);
  assign bit_hit  = tick && (cnt_q == CNT_LAST);
  assign last_bit = (bit_cnt_q == (3'd4 + {1'b0, wls_q}));
  assign start_ok = (state_q == START) && half_hit && !rxd_s;
  assign stop_hit = (state_q == STOP) && bit_hit;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!rxd_s) state_d = START;
      START:     if (half_hit) state_d = rxd_s ? IDLE : DATA;
      DATA:      if (bit_hit && last_bit) state_d = pen_q ? PARITY : STOP;
      PARITY:    if (bit_hit) state_d = STOP;
      STOP:      if (bit_hit) state_d = rxd_s ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rxd_s) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Counter restarts at mid start bit, so its natural wrap lands on each mid-bit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else if ((state_q == IDLE) || ((state_q == START) && half_hit)) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wls_q     <= '0;
      pen_q     <= 1'b0;
      eps_q     <= 1'b0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      stop_q    <= 1'b1;
      load_q    <= 1'b0;
    end else begin
      if (start_ok) begin
        wls_q     <= WLS;
        pen_q     <= PEN;
        eps_q     <= EPS;
        shift_q   <= '0;
        bit_cnt_q <= '0;
        par_q     <= 1'b0;
      end else if ((state_q == DATA) && bit_hit) begin
        shift_q[bit_cnt_q] <= rxd_s;
        bit_cnt_q          <= bit_cnt_q + 3'd1;
      end
      if ((state_q == PARITY) && bit_hit) par_q <= rxd_s;
      load_q <= stop_hit;
      if (stop_hit) stop_q <= rxd_s;
    end
  end

  assign par_x  = (^shift_q) ^ par_q;
  assign new_pe = pen_q & (eps_q ? par_x : ~par_x);
  assign new_fe = ~stop_q;
  assign new_bi = (shift_q == '0) & ~(pen_q & par_q) & ~stop_q;

  // A load coinciding with RD_ACK replaces the held character instead of overrunning.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RX_DATA  <= '0;
      RX_VALID <= 1'b0;
      PE       <= 1'b0;
      FE       <= 1'b0;
      BI       <= 1'b0;
      OE       <= 1'b0;
    end else if (load_q) begin
      if (RX_VALID && !RD_ACK) begin
        OE <= 1'b1;
      end else begin
        RX_DATA  <= shift_q;
        RX_VALID <= 1'b1;
        PE       <= new_pe;
        FE       <= new_fe;
        BI       <= new_bi;
        OE       <= 1'b0;
      end
    end else if (RD_ACK && RX_VALID) begin
      RX_VALID <= 1'b0;
      PE       <= 1'b0;
      FE       <= 1'b0;
      BI       <= 1'b0;
      OE       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed framing cases plus random
// frames checked against a bit-counting reference model.
module tb_uart_rx_core;

  localparam int unsigned OS = 16;
  localparam int unsigned BT = OS * 4;

  logic       CLK = 1'b0;
  logic       RST;
  logic       BAUD_CLK;
  logic       RXD;
  logic [1:0] WLS;
  logic       PEN;
  logic       EPS;
  logic       RD_ACK;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       PE;
  logic       FE;
  logic       BI;
  logic       OE;

  int n_cmp  = 0;
  int n_fail = 0;
  int unsigned ph = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       pe;
    logic       fe;
    logic       bi;
  } exp_t;

  uart_rx_core #(.OVERSAMPLE(OS)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .BAUD_CLK (BAUD_CLK),
    .RXD      (RXD),
    .WLS      (WLS),
    .PEN      (PEN),
    .EPS      (EPS),
    .RD_ACK   (RD_ACK),
    .RX_DATA  (RX_DATA),
    .RX_VALID (RX_VALID),
    .PE       (PE),
    .FE       (FE),
    .BI       (BI),
    .OE       (OE)
  );

  always #5 CLK = ~CLK;

  // Baud tick level: one CLK high every 4 CLKs, changed on falling CLK edges.
  initial begin
    BAUD_CLK = 1'b0;
    forever begin
      @(negedge CLK);
      ph = (ph + 1) % 4;
      BAUD_CLK = (ph == 0);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1);
  end

  function automatic exp_t ref_model(input logic [7:0] d, input int unsigned wlen,
                                     input logic pen, input logic eps,
                                     input logic par, input logic stop);
    exp_t        e;
    int unsigned mask;
    int unsigned ones;
    mask   = (1 << wlen) - 1;
    e.data = d & mask[7:0];
    ones   = $countones(e.data) + ((pen && par) ? 1 : 0);
    e.pe   = pen && (eps ? (ones % 2 == 1) : (ones % 2 == 0));
    e.fe   = !stop;
    e.bi   = (e.data == 8'h00) && (!pen || !par) && !stop;
    return e;
  endfunction

  function automatic logic good_par(input logic [7:0] d, input int unsigned wlen, input logic eps);
    int unsigned mask;
    logic [7:0]  m;
    mask = (1 << wlen) - 1;
    m    = d & mask[7:0];
    return eps ? ($countones(m) % 2 == 1) : ($countones(m) % 2 == 0);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rx(input string tag, input exp_t e, input logic valid, input logic oe);
    chk({tag, ".data"},  RX_DATA, e.data);
    chk({tag, ".valid"}, {7'd0, RX_VALID}, {7'd0, valid});
    chk({tag, ".pe"},    {7'd0, PE}, {7'd0, e.pe});
    chk({tag, ".fe"},    {7'd0, FE}, {7'd0, e.fe});
    chk({tag, ".bi"},    {7'd0, BI}, {7'd0, e.bi});
    chk({tag, ".oe"},    {7'd0, OE}, {7'd0, oe});
  endtask

  task automatic chk_clear(input string tag);
    chk({tag, ".valid"}, {7'd0, RX_VALID}, 8'd0);
    chk({tag, ".flags"}, {4'd0, PE, FE, BI, OE}, 8'd0);
  endtask

  task automatic bit_out(input logic v);
    RXD = v;
    repeat (BT) @(negedge CLK);
  endtask

  task automatic idle_bits(input int unsigned n);
    RXD = 1'b1;
    repeat (n * BT) @(negedge CLK);
  endtask

  task automatic ack();
    RD_ACK = 1'b1;
    @(negedge CLK);
    RD_ACK = 1'b0;
    @(negedge CLK);
  endtask

  task automatic align();
    do @(posedge CLK); while (ph != 0);
    @(negedge CLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input int unsigned wlen, input logic pen,
                            input logic par, input logic stop, input logic scramble);
    bit_out(1'b0);
    if (scramble) begin
      WLS = 2'($urandom);
      PEN = 1'($urandom);
      EPS = 1'($urandom);
    end
    for (int unsigned i = 0; i < wlen; i++) bit_out(d[i]);
    if (pen) bit_out(par);
    bit_out(stop);
  endtask

  initial begin
    exp_t        e;
    int unsigned wlen;
    int unsigned lat;
    logic        found;
    logic [7:0]  d;
    logic        p, ep, par, stp;

    RST    = 1'b1;
    RXD    = 1'b1;
    WLS    = 2'b11;
    PEN    = 1'b0;
    EPS    = 1'b0;
    RD_ACK = 1'b0;
    repeat (3) @(negedge CLK);
    chk_rx("reset", '0, 1'b0, 1'b0);
    RST = 1'b0;
    idle_bits(1);

    // 8N1 0xA5
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_rx("8n1_a5", ref_model(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1, 1'b0);
    ack();
    chk_clear("8n1_ack");

    // 7E1 0x41 with a wrong parity bit
    WLS = 2'b10; PEN = 1'b1; EPS = 1'b1;
    par = ~good_par(8'h41, 7, 1'b1);
    send_frame(8'h41, 7, 1'b1, par, 1'b1, 1'b0);
    e = ref_model(8'h41, 7, 1'b1, 1'b1, par, 1'b1);
    chk("7e1_pe_model", {7'd0, e.pe}, 8'd1);
    chk_rx("7e1_badpar", e, 1'b1, 1'b0);
    ack();
    chk_clear("7e1_ack");
    ack();
    chk("ack_idle.data", RX_DATA, 8'h41);
    chk_clear("ack_idle");

    // False start: low for 4 ticks only
    WLS = 2'b11; PEN = 1'b0; EPS = 1'b0;
    RXD = 1'b0;
    repeat (16) @(negedge CLK);
    idle_bits(2);
    chk("false_start.valid", {7'd0, RX_VALID}, 8'd0);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_rx("after_false", ref_model(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1, 1'b0);
    ack();

    // Break: line low 12 bit times
    RXD = 1'b0;
    repeat (12 * BT) @(negedge CLK);
    chk_rx("break", ref_model(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0);
    ack();
    repeat (3 * BT) @(negedge CLK);
    chk("break_hold.valid", {7'd0, RX_VALID}, 8'd0);
    idle_bits(2);
    chk("break_release.valid", {7'd0, RX_VALID}, 8'd0);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_rx("after_break", ref_model(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1, 1'b0);
    ack();
    idle_bits(1);

    // Overrun: 0x11 then 0x22 without RD_ACK; first frame also measures load latency
    align();
    lat   = 0;
    found = 1'b0;
    fork
      send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b0);
      begin
        while (!found && lat < 2000) begin
          @(negedge CLK);
          lat++;
          if (RX_VALID === 1'b1) found = 1'b1;
        end
      end
    join
    chk("load_seen", {7'd0, found}, 8'd1);
    chk_rx("ovr_first", ref_model(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1, 1'b0);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_rx("ovr_second", ref_model(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1, 1'b1);
    ack();
    chk_clear("ovr_ack");
    idle_bits(1);

    // Same pair, RD_ACK coinciding with the second load
    align();
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    if (found) begin
      fork
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        begin
          repeat (lat - 1) @(negedge CLK);
          RD_ACK = 1'b1;
          @(negedge CLK);
          RD_ACK = 1'b0;
        end
      join
    end
    chk_rx("ack_on_load", ref_model(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1, 1'b0);
    ack();
    idle_bits(1);

    // Reset in the middle of DATA while a character is held
    send_frame(8'h99, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("pre_rst.valid", {7'd0, RX_VALID}, 8'd1);
    bit_out(1'b0);
    bit_out(1'b0);
    bit_out(1'b0);
    RXD = 1'b1;
    repeat (20) @(negedge CLK);
    #2 RST = 1'b1;
    #1 chk_rx("async_rst", '0, 1'b0, 1'b0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    idle_bits(2);
    chk("post_rst.valid", {7'd0, RX_VALID}, 8'd0);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_rx("post_rst_3c", ref_model(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1, 1'b0);
    ack();
    idle_bits(1);

    // Random formats; config pins are scrambled once the start bit is taken
    for (int k = 0; k < 16; k++) begin
      wlen = $urandom_range(8, 5);
      p    = 1'($urandom);
      ep   = 1'($urandom);
      d    = 8'($urandom);
      par  = good_par(d, wlen, ep) ^ ($urandom_range(3, 0) == 0);
      stp  = ($urandom_range(4, 0) != 0);
      WLS  = 2'(wlen - 5);
      PEN  = p;
      EPS  = ep;
      send_frame(d, wlen, p, par, stp, 1'b1);
      chk_rx($sformatf("rnd%0d", k), ref_model(d, wlen, p, ep, par, stp), 1'b1, 1'b0);
      idle_bits(1);
      ack();
      chk_clear($sformatf("rnd%0d_ack", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
